// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: hold, shift, rotate and parallel load,
// with a registered serial-out bit and a serial-shift frame counter/pulse.
module universal_shift_register #(
   parameter int unsigned          WIDTH     = 8,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0,
   localparam int unsigned         CW        = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic [2:0]       mode_i,
   input  logic             x_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] sr_o,
   output logic             so_o,
   output logic [CW-1:0]    cnt_o,
   output logic             frame_o
);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_ROL  = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_LOAD = 3'b101;

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr_q, sr_d;
   logic             so_q, so_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             frame_q, frame_d;
   logic             serial_shift;

   // Next-state: operation select, then frame counting for serial shifts only.
   always_comb begin
      sr_d         = sr_q;
      so_d         = so_q;
      cnt_d        = cnt_q;
      frame_d      = 1'b0;
      serial_shift = 1'b0;

      if (en_i) begin
         case (mode_i)
            MODE_HOLD: ;
            MODE_SHL: begin
               sr_d         = {sr_q[WIDTH-2:0], x_i};
               so_d         = sr_q[WIDTH-1];
               serial_shift = 1'b1;
            end
            MODE_SHR: begin
               sr_d         = {x_i, sr_q[WIDTH-1:1]};
               so_d         = sr_q[0];
               serial_shift = 1'b1;
            end
            MODE_ROL: begin
               sr_d = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
               so_d = sr_q[WIDTH-1];
            end
            MODE_ROR: begin
               sr_d = {sr_q[0], sr_q[WIDTH-1:1]};
               so_d = sr_q[0];
            end
            MODE_LOAD: begin
               sr_d  = d_i;
               cnt_d = '0;
            end
            default: ;
         endcase
      end

      if (serial_shift) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            frame_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q    <= RESET_VAL;
         so_q    <= 1'b0;
         cnt_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         so_q    <= so_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
      end
   end

   assign sr_o    = sr_q;
   assign so_o    = so_q;
   assign cnt_o   = cnt_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register (WIDTH=4 and WIDTH=8 instances).
module tb_universal_shift_register;

   logic       clk = 1'b0;
   logic       reset;

   logic       en4, x4;
   logic [2:0] mode4;
   logic [3:0] d4, sr4;
   logic       so4, frame4;
   logic [1:0] cnt4;

   logic       en8, x8;
   logic [2:0] mode8;
   logic [7:0] d8, sr8;
   logic       so8, frame8;
   logic [2:0] cnt8;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   universal_shift_register #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .en_i(en4), .mode_i(mode4), .x_i(x4), .d_i(d4),
      .sr_o(sr4), .so_o(so4), .cnt_o(cnt4), .frame_o(frame4)
   );

   universal_shift_register #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
      .clk(clk), .reset(reset), .en_i(en8), .mode_i(mode8), .x_i(x8), .d_i(d8),
      .sr_o(sr8), .so_o(so8), .cnt_o(cnt8), .frame_o(frame8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] e_sr, input logic e_so,
                       input logic [1:0] e_cnt, input logic e_fr);
      chk({tag, ".sr"},    32'(sr4),    32'(e_sr));
      chk({tag, ".so"},    32'(so4),    32'(e_so));
      chk({tag, ".cnt"},   32'(cnt4),   32'(e_cnt));
      chk({tag, ".frame"}, 32'(frame4), 32'(e_fr));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive4(input logic en, input logic [2:0] mode, input logic x, input logic [3:0] d);
      en4 = en; mode4 = mode; x4 = x; d4 = d;
   endtask

   initial begin
      reset = 1'b1;
      drive4(1'b0, 3'b000, 1'b0, 4'h0);
      en8 = 1'b0; mode8 = 3'b000; x8 = 1'b0; d8 = 8'h00;
      #22;
      chk4("rst", 4'b0000, 1'b0, 2'd0, 1'b0);
      chk("rst8.sr", 32'(sr8), 32'h0000_00A5);
      reset = 1'b0;
      tick();

      // 1: SHL 1,0,1,1 completes a frame
      drive4(1'b1, 3'b001, 1'b1, 4'h0); tick(); chk4("t1.s1", 4'b0001, 1'b0, 2'd1, 1'b0);
      x4 = 1'b0;                        tick(); chk4("t1.s2", 4'b0010, 1'b0, 2'd2, 1'b0);
      x4 = 1'b1;                        tick(); chk4("t1.s3", 4'b0101, 1'b0, 2'd3, 1'b0);
      x4 = 1'b1;                        tick(); chk4("t1.s4", 4'b1011, 1'b0, 2'd0, 1'b1);
      drive4(1'b1, 3'b000, 1'b0, 4'h0); tick(); chk4("t1.hold", 4'b1011, 1'b0, 2'd0, 1'b0);

      // 2: LOAD then SHR
      drive4(1'b1, 3'b101, 1'b0, 4'b1001); tick(); chk4("t2.load", 4'b1001, 1'b0, 2'd0, 1'b0);
      drive4(1'b1, 3'b010, 1'b0, 4'h0);    tick(); chk4("t2.shr",  4'b0100, 1'b1, 2'd1, 1'b0);

      // 3: LOAD restarts frame; ROL does not count
      drive4(1'b1, 3'b101, 1'b0, 4'b1000); tick(); chk4("t3.load", 4'b1000, 1'b1, 2'd0, 1'b0);
      drive4(1'b1, 3'b011, 1'b0, 4'h0);
      tick(); chk4("t3.rol1", 4'b0001, 1'b1, 2'd0, 1'b0);
      tick(); chk4("t3.rol2", 4'b0010, 1'b0, 2'd0, 1'b0);
      tick(); chk4("t3.rol3", 4'b0100, 1'b0, 2'd0, 1'b0);
      tick(); chk4("t3.rol4", 4'b1000, 1'b0, 2'd0, 1'b0);

      // 4: enable gap mid-frame
      drive4(1'b1, 3'b001, 1'b1, 4'h0);
      tick(); chk4("t4.s1", 4'b0001, 1'b1, 2'd1, 1'b0);
      tick(); chk4("t4.s2", 4'b0011, 1'b0, 2'd2, 1'b0);
      en4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); chk4("t4.dis", 4'b0011, 1'b0, 2'd2, 1'b0);
      end
      drive4(1'b1, 3'b001, 1'b0, 4'h0);
      tick(); chk4("t4.s3", 4'b0110, 1'b0, 2'd3, 1'b0);
      tick(); chk4("t4.s4", 4'b1100, 1'b0, 2'd0, 1'b1);
      en4 = 1'b0;
      tick(); chk4("t4.offpulse", 4'b1100, 1'b0, 2'd0, 1'b0);

      // 5: async reset mid-frame
      drive4(1'b1, 3'b001, 1'b1, 4'h0);
      tick(); chk4("t5.s1", 4'b1001, 1'b1, 2'd1, 1'b0);
      tick(); chk4("t5.s2", 4'b0011, 1'b1, 2'd2, 1'b0);
      #2 reset = 1'b1;
      #1 chk4("t5.arst", 4'b0000, 1'b0, 2'd0, 1'b0);
      chk("t5.arst8", 32'(sr8), 32'h0000_00A5);
      #1 reset = 1'b0;
      tick(); chk4("t5.f1", 4'b0001, 1'b0, 2'd1, 1'b0);
      tick(); chk4("t5.f2", 4'b0011, 1'b0, 2'd2, 1'b0);
      tick(); chk4("t5.f3", 4'b0111, 1'b0, 2'd3, 1'b0);
      tick(); chk4("t5.f4", 4'b1111, 1'b0, 2'd0, 1'b1);

      // ROR and the upper hold codes
      drive4(1'b1, 3'b101, 1'b0, 4'b0001); tick(); chk4("ror.load", 4'b0001, 1'b0, 2'd0, 1'b0);
      drive4(1'b1, 3'b100, 1'b0, 4'h0);    tick(); chk4("ror.1",    4'b1000, 1'b1, 2'd0, 1'b0);
      drive4(1'b1, 3'b110, 1'b0, 4'hF);    tick(); chk4("hold110",  4'b1000, 1'b1, 2'd0, 1'b0);
      drive4(1'b1, 3'b111, 1'b0, 4'hF);    tick(); chk4("hold111",  4'b1000, 1'b1, 2'd0, 1'b0);
      drive4(1'b0, 3'b000, 1'b0, 4'h0);

      // 6: WIDTH=8 back-to-back frames
      chk("t6.rstval", 32'(sr8), 32'h0000_00A5);
      en8 = 1'b1; mode8 = 3'b001; x8 = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         chk($sformatf("t6.frame%0d", c), 32'(frame8), 32'((c == 8) || (c == 16)));
         chk($sformatf("t6.cnt%0d", c), 32'(cnt8), 32'(c % 8));
         if (c == 1) chk("t6.so1", 32'(so8), 32'd1);
         if (c == 8 || c == 16) chk($sformatf("t6.sr%0d", c), 32'(sr8), 32'h0000_00FF);
      end
      en8 = 1'b0;
      tick(); chk("t6.after", 32'(frame8), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
